seq_detector_mc: RTL
====================

# seq_detector_mc

Parametrised, multi-channel successor to the chapter's two-input Moore FSM exercise. The block runs NCH independent serial sequence-detector state machines against one shared, runtime-programmable PAT_LEN-bit pattern. Each channel has:
- a valid-qualified input;
- a selectable overlapping or non-overlapping detection mode;
- a registered one-cycle match pulse;
- a saturating match counter.

## Interface
- NCH, 4: number of independent serial channels (≥1)
- PAT_LEN, 4: pattern length in bits (≥2)
- CNT_W, 8: width of each per-channel match counter (≥1)
- PAT_RST, 4'b1011 (PAT_LEN bits): pattern register value after reset
- clk  in  1  single clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  din valid; channels sample din only on edges where en=1
- din  in  NCH  serial data, bit k belongs to channel k
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled every accepted edge
- cfg_we  in  1  load cfg_pattern into pattern register
- cfg_pattern  in  PAT_LEN  new pattern; MSB = oldest bit of sequence
- cnt_clr  in  1  synchronous clear of all match counters
- match  out  NCH  registered one-cycle pulse per channel
- match_cnt  out  NCH*CNT_W  packed counters, channel k at [k*CNT_W +: CNT_W]

## Operation
- Per channel state:
  - window shift register (PAT_LEN bits, newest bit enters at LSB);
  - fill counter, $clog2(PAT_LEN+1) bits, saturating at PAT_LEN;
  - FSM state: S_EMPTY (fill=0), S_FILL (0<fill<PAT_LEN), S_ARMED (fill=PAT_LEN).
- Accepted edge (en=1, cfg_we=0):
  - window_n = {window[PAT_LEN-2:0], din[k]};
  - fill_n = min(fill+1, PAT_LEN);
  - hit = (fill_n==PAT_LEN) && (window_n==pattern).
- On hit:
  - match[k]=1 next cycle;
  - counter increments unless already saturated at 2^CNT_W−1;
  - overlap=0: fill→0, state→S_EMPTY, window retains bits but is ignored until refilled;
  - overlap=1: stay S_ARMED.
- No hit: state follows fill_n (EMPTY→FILL→ARMED).
- en=0 edge: window, fill and state hold; match goes 0.
- cfg_we=1 edge:
  - pattern ← cfg_pattern;
  - every channel's fill → 0 (S_EMPTY) and match → 0;
  - din/en ignored that edge;
  - counters untouched.
- cnt_clr=1 edge: all counters → 0. Clear beats a simultaneous increment (result 0).
- Priority: rst > cfg_we > en. cnt_clr is independent of cfg_we/en.

## Timing
- Reset (async assert, any time) forces immediately:
  - match=0;
  - match_cnt=0;
  - all fills 0 (S_EMPTY);
  - pattern=PAT_RST;
  - window=0.
- Release is synchronous to clk; the first edge with rst=0 may accept data.
- Latency: the bit completing the pattern is sampled at edge N; match high during cycle N→N+1 and low after N+1 unless another hit occurs.
- match_cnt updates on the same edge that raises match (both registered).
- Minimum spacing between matches on one channel:
  - 1 accepted bit in overlap mode (e.g. pattern 1111 on a stream of ones);
  - PAT_LEN accepted bits in non-overlap mode.
- Channels are fully independent; simultaneous hits on all NCH channels are legal.

## Structure
- Package seq_det_pkg: typedef enum logic [1:0] {S_EMPTY, S_FILL, S_ARMED} det_state_t.
- Sub-module seq_det_chan: window, fill, state, match flop and saturating counter for one channel.
- Top seq_detector_mc:
  - owns the pattern register and priority decode;
  - instantiates NCH seq_det_chan in a generate loop.

## Test plan
Default parameters unless noted.
- Reset, pattern 1011, en=1, din[0]=1,0,1,1, other channels 0 → match[0]=1 exactly one cycle after 4th edge; cnt[0]=1, cnt[1..3]=0.
- overlap=1, din[0]=1,0,1,1,0,1,1 → matches after edges 4 and 7, cnt=2. Repeat after reset with overlap=0 → single match, cnt=1.
- din[1]=1,0, then en=0 for 3 cycles with din toggling, then en=1 with 1,1 → one match after final edge; no match during gap.
- After din[2]=1,0,1: cfg_we with cfg_pattern=0000 → fill cleared. Then din=0,0,0 gives no match; a 4th 0 gives match, and continued zeros match every edge in overlap mode.
- CNT_W=2, 5 matches on channel 3 → cnt[3]=3 (saturated). cnt_clr coincident with a 6th hit → cnt[3]=0, match[3]=1.
- Assert rst between edges mid-stream with cnt[0]=2 and pattern 0000 → match, cnt drop to 0 without a clock; pattern back to 1011; first bits after release start from S_EMPTY.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types for the multi-channel serial sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FILL,
        S_ARMED
    } det_state_t;

endpackage

// File: rtl/seq_detector_mc_if.sv
// Data, configuration and result bundle of seq_detector_mc.
interface seq_detector_mc_if #(
    parameter int NCH     = 4,
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);
    logic                   en;
    logic [NCH-1:0]         din;
    logic                   overlap;
    logic                   cfg_we;
    logic [PAT_LEN-1:0]     cfg_pattern;
    logic                   cnt_clr;
    logic [NCH-1:0]         match;
    logic [NCH*CNT_W-1:0]   match_cnt;

    modport master (
        output en, din, overlap, cfg_we, cfg_pattern, cnt_clr,
        input  match, match_cnt
    );

    modport slave (
        input  en, din, overlap, cfg_we, cfg_pattern, cnt_clr,
        output match, match_cnt
    );
endinterface

// File: rtl/seq_det_chan.sv
// One detector channel: shift window, fill tracking FSM, match pulse and
// saturating match counter.
module seq_det_chan
    import seq_det_pkg::*;
#(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               accept,
    input  logic               flush,
    input  logic               din,
    input  logic               overlap,
    input  logic               cnt_clr,
    input  logic [PAT_LEN-1:0] pattern,
    output logic               match,
    output logic [CNT_W-1:0]   cnt
);
    localparam int              FW      = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]   FULL    = FW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    det_state_t         state;
    logic [PAT_LEN-1:0] window;
    logic [PAT_LEN-1:0] window_n;
    logic [FW-1:0]      fill;
    logic [FW-1:0]      fill_n;
    logic               full_n;
    logic               hit;

    // NOTE: every always_comb output is assigned unconditionally, so no latch.
    always_comb begin
        window_n = {window[PAT_LEN-2:0], din};
        full_n   = (state == S_ARMED) || (fill == FULL - FW'(1));
        fill_n   = full_n ? FULL : fill + FW'(1);
        hit      = accept && full_n && (window_n == pattern);
    end

    // NOTE: state is updated with <= so all flops see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: window is reset too so a post-reset compare never sees X.
            window <= '0;
            fill   <= '0;
            state  <= S_EMPTY;
            match  <= 1'b0;
            cnt    <= '0;
        end else begin
            if (flush) begin
                fill  <= '0;
                state <= S_EMPTY;
                match <= 1'b0;
            end else if (accept) begin
                window <= window_n;
                match  <= hit;
                // Non-overlap restarts the fill; stale window bits are ignored.
                if (hit && !overlap) begin
                    fill  <= '0;
                    state <= S_EMPTY;
                end else begin
                    fill  <= fill_n;
                    state <= full_n ? S_ARMED : S_FILL;
                end
            end else begin
                match <= 1'b0;
            end

            if (cnt_clr) begin
                cnt <= '0;
            end else if (hit && cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_detector_mc.sv
// NCH independent serial sequence detectors sharing one programmable pattern.
module seq_detector_mc
    import seq_det_pkg::*;
#(
    parameter int                 NCH     = 4,
    parameter int                 PAT_LEN = 4,
    parameter int                 CNT_W   = 8,
    parameter logic [PAT_LEN-1:0] PAT_RST = 4'b1011
) (
    input logic               clk,
    input logic               rst,
    seq_detector_mc_if.slave  bus
);
    logic [PAT_LEN-1:0]   pattern;
    logic                 accept;
    logic [NCH-1:0]       match;
    logic [NCH*CNT_W-1:0] cnt;

    // A pattern load flushes every channel and masks din on that edge.
    assign accept = bus.en && !bus.cfg_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern <= PAT_RST;
        end else if (bus.cfg_we) begin
            pattern <= bus.cfg_pattern;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        seq_det_chan #(
            .PAT_LEN (PAT_LEN),
            .CNT_W   (CNT_W)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .accept  (accept),
            .flush   (bus.cfg_we),
            .din     (bus.din[k]),
            .overlap (bus.overlap),
            .cnt_clr (bus.cnt_clr),
            .pattern (pattern),
            .match   (match[k]),
            .cnt     (cnt[k*CNT_W +: CNT_W])
        );
    end

    assign bus.match     = match;
    assign bus.match_cnt = cnt;

endmodule
